axis_pkt_arbiter: RTL and testbench
===================================

Name: axis_pkt_arbiter

Overview:
- Shares one AXI-Stream injection port of an axis_mesh router node between NUM_PORTS traffic sources, for example several num_gen instances behind one mesh endpoint.
- Arbitration is packet-atomic and round-robin: once a source wins, it keeps the port until its TLAST beat is accepted.
- The output is registered, so mesh tready timing is decoupled from the sources.
- A packet counter is provided for bench and debug visibility.

Parameters:
- NUM_PORTS, 2: number of slave (requester) ports, 2..8.
- TDATAW, 32: TDATA width.
- TDESTW, 4: TDEST width; matches the mesh TDEST_WIDTH.
- CNTW, 16: width of PKT_CNT.

Ports:
- CLK  in  1  single clock for the whole block.
- RST_N  in  1  asynchronous, active-low reset.
- AXIS_S_TVALID  in  NUM_PORTS  per-port valid; bit i belongs to port i.
- AXIS_S_TREADY  out  NUM_PORTS  per-port ready.
- AXIS_S_TDATA  in  NUM_PORTS*TDATAW  port i data at [i*TDATAW +: TDATAW].
- AXIS_S_TLAST  in  NUM_PORTS  per-port last.
- AXIS_S_TDEST  in  NUM_PORTS*TDESTW  port i dest at [i*TDESTW +: TDESTW].
- AXIS_M_TVALID  out  1  registered output valid, to mesh axis_in_tvalid.
- AXIS_M_TREADY  in  1  from mesh axis_in_tready.
- AXIS_M_TDATA  out  TDATAW  registered data.
- AXIS_M_TLAST  out  1  registered last.
- AXIS_M_TDEST  out  TDESTW  registered dest.
- GRANT  out  NUM_PORTS  one-hot port currently holding or winning the output; 0 when nothing is granted.
- BUSY  out  1  high while in LOCKED.
- PKT_CNT  out  CNTW  count of TLAST beats accepted on the master side.

Behaviour:
- Reset, asynchronous while RST_N=0:
  - AXIS_M_TVALID=0, AXIS_M_TDATA=0, AXIS_M_TLAST=0, AXIS_M_TDEST=0.
  - AXIS_S_TREADY=0, GRANT=0, BUSY=0, PKT_CNT=0.
  - State=IDLE, round-robin pointer PTR=0.
- Output slot free: out_free = !AXIS_M_TVALID || AXIS_M_TREADY.
- IDLE:
  - gnt is the first i with AXIS_S_TVALID[i]=1, scanning PTR, PTR+1, … modulo NUM_PORTS. This is combinational.
  - GRANT=onehot(gnt); GRANT=0 if no port is valid.
  - AXIS_S_TREADY[gnt]=out_free; every other ready bit is 0.
- LOCKED (lock_id registered):
  - GRANT=onehot(lock_id).
  - AXIS_S_TREADY[lock_id]=out_free; every other ready bit is 0.
  - Other ports' TVALID are ignored.
- Accept: a beat is accepted when AXIS_S_TVALID[g] && AXIS_S_TREADY[g] for the granted g. On the next edge:
  - TDATA, TLAST and TDEST are loaded into the output register.
  - AXIS_M_TVALID becomes 1.
  - Latency is exactly 1 cycle, input accept to AXIS_M_TVALID.
- Transitions:
  - IDLE, accept with TLAST=0: go to LOCKED, lock_id=gnt.
  - IDLE, accept with TLAST=1 (single-beat packet): stay in IDLE, PTR=gnt+1 mod N.
  - LOCKED, accept with TLAST=1: go to IDLE, PTR=lock_id+1 mod N.
  - Any other case: hold state.
- Output register:
  - If AXIS_M_TREADY=1 and no new beat is loaded, AXIS_M_TVALID goes to 0 on the next edge.
  - Simultaneous drain and load keeps AXIS_M_TVALID=1 with the new beat. Full throughput of 1 beat/cycle is sustained while AXIS_M_TREADY=1.
  - While AXIS_M_TVALID=1 and AXIS_M_TREADY=0, all output fields hold stable and all AXIS_S_TREADY=0.
- TDEST is forwarded per beat unchanged. Sources must keep TDEST constant within a packet; the block does not check this.
- A source dropping TVALID mid-packet while LOCKED does not release the lock; the block waits indefinitely.
- PKT_CNT increments by 1 on every AXIS_M_TVALID && AXIS_M_TREADY && AXIS_M_TLAST and wraps from 2^CNTW-1 to 0.
- A reset asserted mid-packet:
  - returns the block to IDLE, PTR=0;
  - drops any beat held in the output register (no flush);
  - leaves the partial packet unterminated. Sources must be reset together with this block.
- No combinational path from AXIS_M_TREADY to AXIS_M_* outputs. The path AXIS_M_TREADY → AXIS_S_TREADY is combinational and permitted.

Test Plan:
- Single source, NUM_PORTS=2, M_TREADY=1:
  - Stimulus: port0 sends 4 beats 0xA0..0xA3, TDEST=3, TLAST on the 4th.
  - Required: M_TVALID one cycle after each accept; data A0..A3 on consecutive cycles; TDEST=3; PKT_CNT=1; afterwards PTR=1, BUSY=0.
- Contention:
  - Stimulus: ports 0 and 1 both valid at the same edge, each with a 3-beat packet (0x10.. and 0x20..), starting from PTR=0.
  - Required: all of port0's packet (0x10,0x11,0x12) goes out first, then port1's (0x20..0x22), with no interleaving; GRANT=01 then 10; PKT_CNT=2.
- Round-robin fairness:
  - Stimulus: both ports continuously send 1-beat packets.
  - Required: output alternates 0,1,0,1 over 8 beats; PKT_CNT=8.
- Backpressure:
  - Stimulus: M_TREADY=0 for 5 cycles mid-packet, with a beat 0x55 already held in the output register.
  - Required: M_TDATA=0x55 held stable and S_TREADY=0 during the stall; the beat after 0x55 appears the cycle after M_TREADY=1; no beats lost or duplicated.
- Lock hold:
  - Stimulus: port1 locked mid-packet drops TVALID for 3 cycles while port0 is valid.
  - Required: port0 is never granted until port1's TLAST is accepted.
- Reset mid-packet and counter wrap:
  - Stimulus: assert RST_N=0 during beat 2 of a 4-beat packet. Separately, with CNTW=4, send 17 packets.
  - Required: reset immediately forces all outputs to 0. PKT_CNT reads 1 after the 17th packet.

Source files
------------

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter
// Packet-atomic round-robin arbiter that shares one AXI-Stream injection port
// of a mesh router node between NUM_PORTS traffic sources. A source that wins
// keeps the output until its TLAST beat has been accepted. The master side is
// a single registered slot, so mesh tready never reaches the master outputs
// through logic.
//
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   AXIS_S_*              NUM_PORTS slave streams, port i in slice i
//   AXIS_M_*              registered master stream toward the mesh
//   GRANT                 one-hot port holding or winning the output, 0 if none
//   BUSY                  high while a multi-beat packet holds the lock
//   PKT_CNT               wrapping count of TLAST beats accepted on the master side
module axis_pkt_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int TDATAW    = 32,
  parameter int TDESTW    = 4,
  parameter int CNTW      = 16
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [NUM_PORTS-1:0]        AXIS_S_TVALID,
  output logic [NUM_PORTS-1:0]        AXIS_S_TREADY,
  input  logic [NUM_PORTS*TDATAW-1:0] AXIS_S_TDATA,
  input  logic [NUM_PORTS-1:0]        AXIS_S_TLAST,
  input  logic [NUM_PORTS*TDESTW-1:0] AXIS_S_TDEST,
  output logic                        AXIS_M_TVALID,
  input  logic                        AXIS_M_TREADY,
  output logic [TDATAW-1:0]           AXIS_M_TDATA,
  output logic                        AXIS_M_TLAST,
  output logic [TDESTW-1:0]           AXIS_M_TDEST,
  output logic [NUM_PORTS-1:0]        GRANT,
  output logic                        BUSY,
  output logic [CNTW-1:0]             PKT_CNT
);

  localparam int IDXW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state;
  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  lock_id;

  logic [IDXW-1:0]  rr_idx;
  logic             rr_found;
  logic [IDXW-1:0]  scan_idx;

  logic [IDXW-1:0]  grant_idx;
  logic             grant_vld;
  logic [NUM_PORTS-1:0] grant_oh;
  logic             out_free;
  logic             accept;
  logic [TDATAW-1:0] sel_data;
  logic [TDESTW-1:0] sel_dest;
  logic             sel_last;

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
    if (i == IDXW'(NUM_PORTS - 1)) return '0;
    return i + IDXW'(1);
  endfunction

  // Round-robin search: first valid port starting at ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = IDXW'((int'(ptr) + k) % NUM_PORTS);
      if (!rr_found && AXIS_S_TVALID[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end
  end

  // While locked, other ports' valids are ignored. Grant is forced off during
  // reset so no source sees ready before the block is running.
  assign grant_idx = (state == ST_LOCKED) ? lock_id : rr_idx;
  assign grant_vld = RST_N && ((state == ST_LOCKED) || rr_found);
  assign grant_oh  = grant_vld ? (NUM_PORTS'(1) << grant_idx) : '0;

  // The single output slot can take a beat when empty or draining this cycle.
  assign out_free      = !AXIS_M_TVALID || AXIS_M_TREADY;
  assign AXIS_S_TREADY = out_free ? grant_oh : '0;
  assign GRANT         = grant_oh;
  assign BUSY          = (state == ST_LOCKED);

  assign sel_data = AXIS_S_TDATA[int'(grant_idx)*TDATAW +: TDATAW];
  assign sel_dest = AXIS_S_TDEST[int'(grant_idx)*TDESTW +: TDESTW];
  assign sel_last = AXIS_S_TLAST[grant_idx];
  assign accept   = grant_vld && out_free && AXIS_S_TVALID[grant_idx];

  // Lock on a non-final beat from IDLE; release and advance the pointer past
  // the winner when a TLAST beat is accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      lock_id <= '0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        if (!sel_last) begin
          state   <= ST_LOCKED;
          lock_id <= grant_idx;
        end else begin
          ptr <= next_idx(grant_idx);
        end
      end else if (sel_last) begin
        state <= ST_IDLE;
        ptr   <= next_idx(lock_id);
      end
    end
  end

  // Output slot: load on accept, otherwise empty once the mesh takes the beat.
  // Fields hold while stalled because accept is impossible then.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      AXIS_M_TVALID <= 1'b0;
      AXIS_M_TDATA  <= '0;
      AXIS_M_TLAST  <= 1'b0;
      AXIS_M_TDEST  <= '0;
    end else if (accept) begin
      AXIS_M_TVALID <= 1'b1;
      AXIS_M_TDATA  <= sel_data;
      AXIS_M_TLAST  <= sel_last;
      AXIS_M_TDEST  <= sel_dest;
    end else if (AXIS_M_TREADY) begin
      AXIS_M_TVALID <= 1'b0;
    end
  end

  // Packet counter on master-side TLAST handshakes, wrapping naturally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PKT_CNT <= '0;
    end else if (AXIS_M_TVALID && AXIS_M_TREADY && AXIS_M_TLAST) begin
      PKT_CNT <= PKT_CNT + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter
// Directed bench for the two-port arbiter. Each scenario pushes the beats it
// expects to see on the master side into a scoreboard queue, then drives the
// sources; an independent monitor pops and compares every master handshake.
// A narrow packet counter makes the wrap scenario short.
module tb_axis_pkt_arbiter;

  localparam int NP   = 2;
  localparam int DW   = 32;
  localparam int DSTW = 4;
  localparam int CW   = 4;
  localparam int BEAT_TIMEOUT = 200;

  typedef struct packed {
    logic            last;
    logic [DSTW-1:0] dest;
    logic [DW-1:0]   data;
  } beat_t;

  logic              CLK;
  logic              RST_N;
  logic [NP-1:0]     AXIS_S_TVALID;
  logic [NP-1:0]     AXIS_S_TREADY;
  logic [NP*DW-1:0]  AXIS_S_TDATA;
  logic [NP-1:0]     AXIS_S_TLAST;
  logic [NP*DSTW-1:0] AXIS_S_TDEST;
  logic              AXIS_M_TVALID;
  logic              AXIS_M_TREADY;
  logic [DW-1:0]     AXIS_M_TDATA;
  logic              AXIS_M_TLAST;
  logic [DSTW-1:0]   AXIS_M_TDEST;
  logic [NP-1:0]     GRANT;
  logic              BUSY;
  logic [CW-1:0]     PKT_CNT;

  logic              s_valid [NP];
  logic [DW-1:0]     s_data  [NP];
  logic              s_last  [NP];
  logic [DSTW-1:0]   s_dest  [NP];
  bit                lastDone [NP];

  beat_t sb [$];
  int checks = 0;
  int errors = 0;

  assign AXIS_S_TVALID = {s_valid[1], s_valid[0]};
  assign AXIS_S_TDATA  = {s_data[1], s_data[0]};
  assign AXIS_S_TLAST  = {s_last[1], s_last[0]};
  assign AXIS_S_TDEST  = {s_dest[1], s_dest[0]};

  axis_pkt_arbiter #(.NUM_PORTS(NP), .TDATAW(DW), .TDESTW(DSTW), .CNTW(CW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .AXIS_S_TVALID(AXIS_S_TVALID), .AXIS_S_TREADY(AXIS_S_TREADY),
    .AXIS_S_TDATA(AXIS_S_TDATA), .AXIS_S_TLAST(AXIS_S_TLAST), .AXIS_S_TDEST(AXIS_S_TDEST),
    .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(AXIS_M_TREADY),
    .AXIS_M_TDATA(AXIS_M_TDATA), .AXIS_M_TLAST(AXIS_M_TLAST), .AXIS_M_TDEST(AXIS_M_TDEST),
    .GRANT(GRANT), .BUSY(BUSY), .PKT_CNT(PKT_CNT)
  );

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case a scenario wedges despite the per-beat bounds.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired actual running required finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic pushPacket(input logic [DW-1:0] base, input int n, input logic [DSTW-1:0] dest);
    beat_t e;
    for (int b = 0; b < n; b++) begin
      e.data = base + DW'(b);
      e.last = (b == n - 1);
      e.dest = dest;
      sb.push_back(e);
    end
  endtask

  // Monitor: every master handshake must match the head of the scoreboard.
  always @(negedge CLK) begin
    beat_t got;
    beat_t exp;
    if (RST_N && AXIS_M_TVALID && AXIS_M_TREADY) begin
      got.data = AXIS_M_TDATA;
      got.last = AXIS_M_TLAST;
      got.dest = AXIS_M_TDEST;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected actual %0h required none", got);
      end else begin
        exp = sb.pop_front();
        checkOutput("sb_beat", 64'(got), 64'(exp));
      end
    end
  end

  // Drives one packet on port p; optionally drops valid for gapCycles before
  // beat gapBeat. After each accept, the beat must sit in the output slot.
  task automatic applyStimulus(input bit p, input logic [DW-1:0] base, input int n,
                               input logic [DSTW-1:0] dest, input int gapBeat, input int gapCycles);
    logic [DW-1:0] d;
    bit accepted;
    int waited;
    logic [NP-1:0] rdy;
    for (int b = 0; b < n; b++) begin
      if (b == gapBeat) begin
        s_valid[p] = 1'b0;
        repeat (gapCycles) @(posedge CLK);
        #1;
      end
      d = base + DW'(b);
      s_valid[p] = 1'b1;
      s_data[p]  = d;
      s_last[p]  = (b == n - 1);
      s_dest[p]  = dest;
      accepted = 1'b0;
      waited = 0;
      while (!accepted && waited < BEAT_TIMEOUT) begin
        @(negedge CLK);
        rdy = AXIS_S_TREADY;
        if (rdy[p]) begin
          @(posedge CLK);
          #1;
          checkOutput("accept_latency", 64'({AXIS_M_TVALID, AXIS_M_TDATA}), 64'({1'b1, d}));
          accepted = 1'b1;
        end else begin
          @(posedge CLK);
          #1;
          waited++;
        end
      end
      if (!accepted) begin
        checks++;
        errors++;
        $display("[TB] FAIL beat_timeout port %0d actual no_accept required accept of %0h", p, d);
        s_valid[p] = 1'b0;
        return;
      end
    end
    s_valid[p] = 1'b0;
    s_last[p]  = 1'b0;
    lastDone[p] = 1'b1;
  endtask

  task automatic resetDut();
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    AXIS_M_TREADY = 1'b1;
    for (int i = 0; i < NP; i++) begin
      s_valid[i] = 1'b0;
      s_last[i]  = 1'b0;
      lastDone[i] = 1'b0;
    end
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic settle();
    repeat (4) @(posedge CLK);
    #1;
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    bit sawP0;
    bit sawBusy;
    bit found;

    RST_N = 1'b0;
    AXIS_M_TREADY = 1'b1;
    for (int i = 0; i < NP; i++) begin
      s_valid[i] = 1'b0;
      s_data[i]  = '0;
      s_last[i]  = 1'b0;
      s_dest[i]  = '0;
      lastDone[i] = 1'b0;
    end
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_master", 64'({AXIS_M_TVALID, AXIS_M_TLAST, AXIS_M_TDEST, AXIS_M_TDATA}), 64'd0);
    checkOutput("reset_status", 64'({AXIS_S_TREADY, GRANT, BUSY, PKT_CNT}), 64'd0);
    RST_N = 1'b1;

    // Single source, four beats with dest 3.
    $display("[TB] single source");
    pushPacket(32'hA0, 4, 4'd3);
    applyStimulus(1'b0, 32'hA0, 4, 4'd3, -1, 0);
    settle();
    checkOutput("single_cnt_busy", 64'({PKT_CNT, BUSY, GRANT}), 64'({4'd1, 1'b0, 2'b00}));

    // Lock hold; pointer is now 1 so port1 wins while both are valid.
    $display("[TB] lock hold");
    pushPacket(32'h30, 4, 4'd5);
    pushPacket(32'h40, 1, 4'd6);
    sawP0 = 1'b0;
    sawBusy = 1'b0;
    fork
      applyStimulus(1'b1, 32'h30, 4, 4'd5, 2, 3);
      applyStimulus(1'b0, 32'h40, 1, 4'd6, -1, 0);
      begin
        @(negedge CLK);
        checkOutput("lock_first_grant", 64'(GRANT), 64'(2'b10));
        for (int i = 0; i < BEAT_TIMEOUT && !lastDone[1]; i++) begin
          if (GRANT[0]) sawP0 = 1'b1;
          if (BUSY) sawBusy = 1'b1;
          @(negedge CLK);
        end
      end
    join
    checkOutput("lock_no_p0_grant", 64'(sawP0), 64'd0);
    checkOutput("lock_busy_seen", 64'(sawBusy), 64'd1);
    settle();
    checkOutput("lock_cnt", 64'(PKT_CNT), 64'd3);

    // Contention from pointer 0: whole packets, port0 first.
    $display("[TB] contention");
    resetDut();
    pushPacket(32'h10, 3, 4'd1);
    pushPacket(32'h20, 3, 4'd2);
    fork
      applyStimulus(1'b0, 32'h10, 3, 4'd1, -1, 0);
      applyStimulus(1'b1, 32'h20, 3, 4'd2, -1, 0);
      begin
        @(negedge CLK);
        checkOutput("contend_grant0", 64'(GRANT), 64'(2'b01));
        for (int i = 0; i < BEAT_TIMEOUT && !lastDone[0]; i++) @(negedge CLK);
        checkOutput("contend_grant1", 64'(GRANT), 64'(2'b10));
      end
    join
    settle();
    checkOutput("contend_cnt", 64'(PKT_CNT), 64'd2);

    // Fairness: single-beat packets alternate between the ports.
    $display("[TB] fairness");
    resetDut();
    for (int k = 0; k < 4; k++) begin
      pushPacket(32'hB0 + DW'(k), 1, 4'd1);
      pushPacket(32'hC0 + DW'(k), 1, 4'd2);
    end
    fork
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 32'hB0 + DW'(k), 1, 4'd1, -1, 0);
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'hC0 + DW'(k), 1, 4'd2, -1, 0);
    join
    settle();
    checkOutput("fair_cnt", 64'(PKT_CNT), 64'd8);

    // Backpressure: stall five cycles while 0x55 sits in the output slot.
    $display("[TB] backpressure");
    resetDut();
    pushPacket(32'h54, 4, 4'd7);
    fork
      applyStimulus(1'b0, 32'h54, 4, 4'd7, -1, 0);
      begin
        found = 1'b0;
        for (int i = 0; i < BEAT_TIMEOUT && !found; i++) begin
          @(posedge CLK);
          #1;
          if (AXIS_M_TVALID && AXIS_M_TDATA == 32'h55) found = 1'b1;
        end
        checkOutput("bp_found_55", 64'(found), 64'd1);
        AXIS_M_TREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge CLK);
          checkOutput("bp_hold", 64'({AXIS_M_TVALID, AXIS_S_TREADY, AXIS_M_TDATA}),
                      64'({1'b1, 2'b00, 32'h55}));
        end
        @(posedge CLK);
        #1;
        AXIS_M_TREADY = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("bp_resume", 64'({AXIS_M_TVALID, AXIS_M_TDATA}), 64'({1'b1, 32'h56}));
      end
    join
    settle();
    checkOutput("bp_cnt", 64'(PKT_CNT), 64'd1);

    // Reset during beat 2 of a four-beat packet: second beat is dropped.
    $display("[TB] reset mid-packet");
    resetDut();
    pushPacket(32'hD0, 1, 4'd4);
    sb[0].last = 1'b0;
    s_valid[0] = 1'b1;
    s_data[0]  = 32'hD0;
    s_last[0]  = 1'b0;
    s_dest[0]  = 4'd4;
    @(posedge CLK);
    #1;
    s_data[0] = 32'hD1;
    @(posedge CLK);
    #1;
    checkOutput("rstmid_before", 64'({AXIS_M_TVALID, BUSY, AXIS_M_TDATA}), 64'({1'b1, 1'b1, 32'hD1}));
    RST_N = 1'b0;
    #1;
    checkOutput("rstmid_master", 64'({AXIS_M_TVALID, AXIS_M_TLAST, AXIS_M_TDEST, AXIS_M_TDATA}), 64'd0);
    checkOutput("rstmid_status", 64'({AXIS_S_TREADY, GRANT, BUSY, PKT_CNT}), 64'd0);
    s_valid[0] = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    settle();

    // Counter wrap with a 4-bit counter: 17 packets leave it at 1.
    $display("[TB] counter wrap");
    resetDut();
    for (int k = 0; k < 17; k++) pushPacket(32'hE0 + DW'(k), 1, 4'd9);
    for (int k = 0; k < 17; k++) applyStimulus(1'b0, 32'hE0 + DW'(k), 1, 4'd9, -1, 0);
    settle();
    checkOutput("wrap_cnt", 64'(PKT_CNT), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
